// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared state encoding, digit width and decimal range helper for bin2bcd_seq
package bin2bcd_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction
endpackage

// File: rtl/bin2bcd_if.sv
// bin2bcd_if: binary request handshake plus BCD result bus between a producer and bin2bcd_seq
interface bin2bcd_if import bin2bcd_pkg::*; #(parameter int DATA_W = 27, parameter int SEG_NUM = 8);
  logic [DATA_W-1:0] bin_in;
  logic bin_vld;
  logic bin_rdy;
  logic [SEG_NUM*DIGIT_W-1:0] dout;
  logic [SEG_NUM-1:0] dout_vld;
  logic ovf;
  modport master(output bin_in, bin_vld, input bin_rdy, dout, dout_vld, ovf);
  modport slave(input bin_in, bin_vld, output bin_rdy, dout, dout_vld, ovf);
endinterface

// File: rtl/bin2bcd_add3.sv
// bin2bcd_add3: double-dabble nibble correction, adds 3 to any digit of 5 or more
module bin2bcd_add3 import bin2bcd_pkg::*; (
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);
  assign q = d >= DIGIT_W'(5) ? d + DIGIT_W'(3) : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-cycle binary to BCD converter with saturation and per-digit change mask
module bin2bcd_seq import bin2bcd_pkg::*; #(
  parameter int DATA_W  = 27,
  parameter int SEG_NUM = 8
) (
  input logic      clk,
  input logic      rst_n,
  bin2bcd_if.slave bus
);
  localparam int BCD_W = SEG_NUM * DIGIT_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [63:0] MAX = pow10_minus1(SEG_NUM);
  state_t state, state_nxt;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q, bcd_adj, result, dout_q;
  logic [CNT_W-1:0] cnt;
  logic ovf_pend, first_result, ovf_q, accept, last;
  logic [SEG_NUM-1:0] vld_q, vld_nxt;
  for (genvar g = 0; g < SEG_NUM; g++) begin : g_add3
    bin2bcd_add3 u_add3 (.d(bcd_q[g*DIGIT_W +: DIGIT_W]), .q(bcd_adj[g*DIGIT_W +: DIGIT_W]));
  end
  assign accept = state == IDLE && bus.bin_vld;
  assign last   = cnt == CNT_W'(DATA_W - 1);
  assign result = ovf_pend ? {SEG_NUM{4'd9}} : bcd_q;
  always_comb begin
    state_nxt = state == IDLE  ? (bus.bin_vld ? SHIFT : IDLE) :
                state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    for (int i = 0; i < SEG_NUM; i++)
      vld_nxt[i] = first_result || result[i*DIGIT_W +: DIGIT_W] != dout_q[i*DIGIT_W +: DIGIT_W];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt          <= '0;
      ovf_pend     <= 1'b0;
      dout_q       <= '0;
      vld_q        <= '0;
      ovf_q        <= 1'b0;
      first_result <= 1'b1;
    end else begin
      state <= state_nxt;
      vld_q <= '0;
      if (accept) begin
        bin_q    <= bus.bin_in;
        bcd_q    <= '0;
        cnt      <= '0;
        ovf_pend <= 64'(bus.bin_in) > MAX;
      end else if (state == SHIFT) begin
        {bcd_q, bin_q} <= {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        cnt            <= cnt + CNT_W'(1);
      end else if (state == DONE) begin
        dout_q       <= result;
        ovf_q        <= ovf_pend;
        vld_q        <= vld_nxt;
        first_result <= 1'b0;
      end
    end
  end
  assign bus.bin_rdy  = state == IDLE;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.ovf      = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed vector table plus back-to-back and mid-conversion reset sequences
module tb_bin2bcd_seq;
  localparam int DATA_W = 27;
  localparam int SEG_NUM = 8;
  typedef struct {
    int unsigned bin;
    logic [31:0] dout;
    logic [7:0]  vld;
    logic        ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  bin2bcd_if #(.DATA_W(DATA_W), .SEG_NUM(SEG_NUM)) bus ();
  bin2bcd_seq #(.DATA_W(DATA_W), .SEG_NUM(SEG_NUM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    if (v > 99999999) return 32'h99999999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  task automatic wait_rdy();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.bin_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("rdy_timeout", 64'(bus.bin_rdy), 64'd1);
  endtask
  task automatic run_vec(input vec_t v);
    logic [31:0] held;
    wait_rdy();
    bus.bin_in  = DATA_W'(v.bin);
    bus.bin_vld = 1'b1;
    @(posedge clk);
    #1 bus.bin_vld = 1'b0;
    for (int e = 1; e < DATA_W + 1; e++) begin
      @(posedge clk);
      #1;
      if (e == DATA_W) begin
        chk("busy_rdy", 64'(bus.bin_rdy), 64'd0);
        chk("early_vld", 64'(bus.dout_vld), 64'd0);
      end
    end
    @(posedge clk);
    #1;
    chk("dout", 64'(bus.dout), 64'(v.dout));
    chk("dout_vld", 64'(bus.dout_vld), 64'(v.vld));
    chk("ovf", 64'(bus.ovf), 64'(v.ovf));
    chk("rdy_back", 64'(bus.bin_rdy), 64'd1);
    held = bus.dout;
    @(posedge clk);
    #1;
    chk("vld_pulse_end", 64'(bus.dout_vld), 64'd0);
    chk("dout_held", 64'(bus.dout), 64'(held));
  endtask
  initial begin
    vec_t tbl[9];
    int unsigned q[$];
    int last_acc, cyc;
    bit feeding;
    tbl[0] = '{12345678,  32'h12345678, 8'hFF, 1'b0};
    tbl[1] = '{12345679,  32'h12345679, 8'h01, 1'b0};
    tbl[2] = '{12345679,  32'h12345679, 8'h00, 1'b0};
    tbl[3] = '{100000000, 32'h99999999, 8'hFE, 1'b1};
    tbl[4] = '{0,         32'h00000000, 8'hFF, 1'b0};
    tbl[5] = '{99999999,  32'h99999999, 8'hFF, 1'b0};
    tbl[6] = '{134217727, 32'h99999999, 8'h00, 1'b1};
    tbl[7] = '{5,         32'h00000005, 8'hFF, 1'b0};
    tbl[8] = '{10,        32'h00000010, 8'h03, 1'b0};
    bus.bin_in  = '0;
    bus.bin_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdy", 64'(bus.bin_rdy), 64'd1);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_vld", 64'(bus.dout_vld), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(tbl[i]);
    // bin_vld held high: accepts only when idle, results follow their accept-edge value
    last_acc = -1;
    feeding = 1'b1;
    for (cyc = 0; cyc < 4 * (DATA_W + 2) + DATA_W + 4; cyc++) begin
      @(negedge clk);
      if (cyc == 3 * (DATA_W + 2) + 1) feeding = 1'b0;
      bus.bin_vld = feeding;
      bus.bin_in  = DATA_W'(1000 + cyc * 7919);
      if (feeding && bus.bin_rdy) begin
        if (last_acc >= 0) chk("accept_spacing", 64'(cyc - last_acc), 64'(DATA_W + 2));
        last_acc = cyc;
        q.push_back(1000 + cyc * 7919);
      end
      @(posedge clk);
      #1;
      if (|bus.dout_vld) begin
        if (q.size() == 0) chk("unexpected_result", 64'(bus.dout), 64'hDEAD);
        else chk("stream_dout", 64'(bus.dout), 64'(to_bcd(q.pop_front())));
      end
    end
    bus.bin_vld = 1'b0;
    chk("stream_drained", 64'(q.size()), 64'd0);
    // reset in the middle of SHIFT aborts the conversion
    wait_rdy();
    bus.bin_in  = DATA_W'(77);
    bus.bin_vld = 1'b1;
    @(posedge clk);
    #1 bus.bin_vld = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", 64'(bus.dout), 64'd0);
    chk("mid_rst_rdy", 64'(bus.bin_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (DATA_W + 5) begin
        @(posedge clk);
        #1 if (|bus.dout_vld) seen = 1'b1;
      end
      chk("abort_no_pulse", 64'(seen), 64'd0);
    end
    chk("abort_dout", 64'(bus.dout), 64'd0);
    chk("abort_ovf", 64'(bus.ovf), 64'd0);
    chk("abort_rdy", 64'(bus.bin_rdy), 64'd1);
    run_vec('{5, 32'h00000005, 8'hFF, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that feeds the 7-segment display driver. It accepts an unsigned binary value through a valid/ready handshake and converts it with a shift-and-add-3 (double-dabble) loop, one bit per cycle. It then presents SEG_NUM packed BCD digits together with a per-digit valid mask. Only digits that changed since the last result are flagged, so the display driver updates only those.

## Interface
- DATA_W, 27, width of binary input; 27 bits cover 0..99,999,999.
- SEG_NUM, 8, number of BCD digits produced.
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- bin_in  input  DATA_W  unsigned binary value.
- bin_vld  input  1  bin_in valid.
- bin_rdy  output  1  converter idle and able to accept.
- dout  output  SEG_NUM*4  packed BCD; digit i is dout[4i+3:4i], digit 0 is least significant.
- dout_vld  output  SEG_NUM  one-cycle pulse mask, one bit per digit whose value changed.
- ovf  output  1  last result was saturated; held until the next result.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - bin_rdy=1.
  - An accept is bin_vld&&bin_rdy at a clock edge.
  - On accept: latch bin_in into the shift register, clear the BCD accumulator (SEG_NUM*4 bits), clear the bit counter, go to SHIFT.
- Saturation: if the latched value exceeds MAX=10^SEG_NUM-1, the conversion still runs, but the final result is forced to all 4'd9 and ovf=1. Otherwise ovf=0.
  - The comparison is made at accept time and stored in a pending-ovf flag.
- SHIFT, one step per cycle for DATA_W cycles:
  - Add 3 to every BCD nibble that is >=5.
  - Shift {bcd,bin} left by one.
  - After the step with counter==DATA_W-1, go to DONE.
- DONE: one cycle, then go to IDLE. On that transition edge:
  - Register dout and ovf.
  - Register dout_vld[i] = (new digit i != current dout digit i) || first_result.
  - first_result is set by reset and cleared on the first completed result.
- bin_rdy=0 in SHIFT and DONE. bin_vld during busy is ignored and is never queued.
- A result that is identical to the previous one completes normally, with dout_vld=0.
- Reset, including mid-SHIFT: the conversion is aborted and no result is issued. State goes to IDLE.
  - Reset values: bin_rdy=1, dout=0, dout_vld=0, ovf=0, first_result=1.

## Timing
- Accept at edge k.
- Shift steps occur at edges k+1 through k+DATA_W.
- The DONE cycle follows edge k+DATA_W.
- dout, ovf and dout_vld update at edge k+DATA_W+1. dout_vld is high for exactly that one cycle.
- bin_rdy returns high in the same cycle that dout_vld is high. A new accept is therefore possible at edge k+DATA_W+2.
- Throughput: one conversion per DATA_W+2 cycles.
- dout holds its value between results; it is always stable when the display driver samples it.
- All outputs are registered; no combinational input-to-output path exists.
- Bit counter width is $clog2(DATA_W). The BCD accumulator has no carry beyond SEG_NUM*4 bits; saturation covers overflow.

## Structure
- Package bin2bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a function pow10_minus1(n) that produces MAX;
  - the digit width constant 4.
- Sub-module bin2bcd_add3: combinational per-nibble correction (in>=5 ? in+3 : in), instantiated SEG_NUM times via generate.
- The top level holds the FSM, counter, shift registers, change-detect logic and output registers.

## Test plan
- Reset, then send 12345678 -> dout=32'h12345678, ovf=0, dout_vld=8'hFF; dout_vld pulses exactly DATA_W+1 edges after accept.
- Then send 12345679 -> dout=32'h12345679, dout_vld=8'h01; then send 12345679 again -> dout unchanged, dout_vld=8'h00, bin_rdy returns on schedule.
- Send 100000000 -> dout=32'h99999999, ovf=1, dout_vld marks only the digits that changed; then send 0 -> dout=0, ovf=0, dout_vld=8'hFF where the previous digits were 9.
- Hold bin_vld high continuously with changing bin_in -> accepts occur only when bin_rdy=1, every DATA_W+2 cycles; each result matches the value present at its accept edge.
- Assert rst_n low for one cycle midway through SHIFT -> no dout_vld pulse, all outputs at reset values, bin_rdy=1; the next conversion of 5 gives dout_vld=8'hFF (first_result).
- Boundaries: 0 -> all zeros; 99999999 -> 32'h99999999 with ovf=0; 2^27-1 -> saturated with ovf=1.
